// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Steps through a microcode ROM addressed by {opcode_q, step_q}. It decodes
//   the returned control word into datapath controls and applies the
//   sequencing bits (reset > halt > control_unit_load > next_instr > increment).
//   It stalls on READ/WRITE until mem_ready, and parks in HALTED until resume.
//
//   Optional feature macro: MICROCODE_STEP_FAULT_EN
//     defined   - incrementing past the last step sets the sticky step_fault
//                 and redirects to {FETCH_OPCODE, 0}
//     undefined - the step counter wraps within the opcode; step_fault is 0
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ir_opcode           opcode from the instruction register
//   ucode_word          combinational ROM data for ucode_addr
//   mem_ready           current READ/WRITE completes this cycle
//   resume              pulse that leaves HALTED
//   ucode_addr          {opcode_q, step_q}
//   alu_op, alu_enable, memory_op, data_word_selector, bus_selector
//                       decoded control fields (zero while halted)
//   reg_load, reg_enable
//                       one bit per general register (zero while halted)
//   halted              high in HALTED
//   step_fault          sticky micro-step overflow flag
module microcode_sequencer #(
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter int unsigned STEP_WIDTH   = 3,
  parameter int unsigned NUM_REGS     = 4,
  parameter int unsigned FETCH_OPCODE = 0,
  localparam int unsigned CW_WIDTH    = 14 + 2 * NUM_REGS,
  localparam int unsigned ADDR_WIDTH  = OPCODE_WIDTH + STEP_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] ir_opcode,
  input  logic [CW_WIDTH-1:0]     ucode_word,
  input  logic                    mem_ready,
  input  logic                    resume,
  output logic [ADDR_WIDTH-1:0]   ucode_addr,
  output logic [3:0]              alu_op,
  output logic                    alu_enable,
  output logic [2:0]              memory_op,
  output logic                    data_word_selector,
  output logic                    bus_selector,
  output logic [NUM_REGS-1:0]     reg_load,
  output logic [NUM_REGS-1:0]     reg_enable,
  output logic                    halted,
  output logic                    step_fault
);

`ifdef MICROCODE_STEP_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam int unsigned MAX_STEPS = 2 ** STEP_WIDTH;
  localparam logic [STEP_WIDTH-1:0]   STEP_LAST = STEP_WIDTH'(MAX_STEPS - 1);
  localparam logic [OPCODE_WIDTH-1:0] FETCH     = OPCODE_WIDTH'(FETCH_OPCODE);

  // Control-word field positions, packed from the MSB down.
  localparam int unsigned ALU_MSB    = CW_WIDTH - 1;
  localparam int unsigned ALU_EN_BIT = CW_WIDTH - 5;
  localparam int unsigned MEM_MSB    = CW_WIDTH - 6;
  localparam int unsigned DWS_BIT    = CW_WIDTH - 9;
  localparam int unsigned BUS_BIT    = CW_WIDTH - 10;
  localparam int unsigned REG0_LSB   = CW_WIDTH - 12;
  localparam int unsigned RST_BIT    = 3;
  localparam int unsigned HALT_BIT   = 2;
  localparam int unsigned CUL_BIT    = 1;
  localparam int unsigned NEXT_BIT   = 0;

  localparam logic [2:0] MEM_NOP   = 3'd0;
  localparam logic [2:0] MEM_READ  = 3'd1;
  localparam logic [2:0] MEM_WRITE = 3'd2;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_ENABLE = 2'd2;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STALL  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic                    fault_q, fault_d;

  logic [2:0] cw_mem;
  logic       mem_access;

  assign cw_mem     = ucode_word[MEM_MSB -: 3];
  assign mem_access = (cw_mem == MEM_READ) || (cw_mem == MEM_WRITE);

  assign ucode_addr = {opcode_q, step_q};
  assign halted     = (state_q == S_HALTED);
  assign step_fault = FAULT_EN & fault_q;

  // State and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      opcode_q <= FETCH;
      step_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      step_q   <= step_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state and sequencing decode.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    step_d   = step_q;
    fault_d  = fault_q;
    case (state_q)
      S_RUN, S_STALL: begin
        if (mem_access && !mem_ready) begin
          // Hold address; every sequencing bit waits for the memory handshake.
          state_d = S_STALL;
        end else begin
          state_d = S_RUN;
          if (ucode_word[RST_BIT]) begin
            opcode_d = FETCH;
            step_d   = '0;
            fault_d  = 1'b0;
          end else if (ucode_word[HALT_BIT]) begin
            state_d  = S_HALTED;
            opcode_d = FETCH;
            step_d   = '0;
          end else if (ucode_word[CUL_BIT]) begin
            opcode_d = ir_opcode;
            step_d   = '0;
          end else if (ucode_word[NEXT_BIT]) begin
            opcode_d = FETCH;
            step_d   = '0;
          end else if (FAULT_EN && (step_q == STEP_LAST)) begin
            fault_d  = 1'b1;
            opcode_d = FETCH;
            step_d   = '0;
          end else begin
            // Natural wrap within the opcode when the fault check is absent.
            step_d = step_q + STEP_WIDTH'(1);
          end
        end
      end
      S_HALTED: begin
        if (resume) begin
          state_d  = S_RUN;
          opcode_d = FETCH;
          step_d   = '0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Control-word decode; everything is quiet while halted.
  always_comb begin
    alu_op             = '0;
    alu_enable         = 1'b0;
    memory_op          = MEM_NOP;
    data_word_selector = 1'b0;
    bus_selector       = 1'b0;
    reg_load           = '0;
    reg_enable         = '0;
    if (state_q != S_HALTED) begin
      alu_op             = ucode_word[ALU_MSB -: 4];
      alu_enable         = ucode_word[ALU_EN_BIT];
      memory_op          = mem_access ? cw_mem : MEM_NOP;
      data_word_selector = ucode_word[DWS_BIT];
      bus_selector       = ucode_word[BUS_BIT];
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        reg_load[i]   = (ucode_word[int'(REG0_LSB) - 2 * i +: 2] == REG_LOAD);
        reg_enable[i] = (ucode_word[int'(REG0_LSB) - 2 * i +: 2] == REG_ENABLE);
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: a ROM table drives ucode_word,
// expected observations are queued when stimulus is applied and compared at
// the following falling edge.
module tb_microcode_sequencer;

  localparam int unsigned OW = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 14 + 2 * NR;
  localparam int unsigned AW = OW + SW;
  localparam int unsigned CW2 = 18;

`ifdef MICROCODE_STEP_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam logic [3:0] SQ_RST = 4'b1000;
  localparam logic [3:0] SQ_HLT = 4'b0100;
  localparam logic [3:0] SQ_CUL = 4'b0010;
  localparam logic [3:0] SQ_NXT = 4'b0001;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          halted;
    logic          fault;
    logic [3:0]    alu_op;
    logic          alu_en;
    logic [2:0]    mem_op;
    logic          dws;
    logic          bus;
    logic [NR-1:0] rld;
    logic [NR-1:0] ren;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [OW-1:0] ir_opcode;
  logic [CW-1:0] ucode_word;
  logic mem_ready, resume;
  logic [AW-1:0] ucode_addr;
  logic [3:0] alu_op;
  logic alu_enable;
  logic [2:0] memory_op;
  logic data_word_selector, bus_selector;
  logic [NR-1:0] reg_load, reg_enable;
  logic halted, step_fault;

  logic [CW2-1:0] w2;
  logic [AW-1:0] ucode_addr2;
  logic [3:0] alu_op2;
  logic alu_enable2;
  logic [2:0] memory_op2;
  logic dws2, bus2;
  logic [1:0] reg_load2, reg_enable2;
  logic halted2, step_fault2;

  logic [CW-1:0] rom [0:(1 << AW) - 1];
  obs_t obs, want;
  logic [23:0] obs2, want2;
  obs_t exp_q[$];
  logic [23:0] exp2_q[$];
  int tests = 0;
  int failed = 0;

  assign ucode_word = rom[ucode_addr];
  assign obs  = {ucode_addr, halted, step_fault, alu_op, alu_enable, memory_op,
                 data_word_selector, bus_selector, reg_load, reg_enable};
  assign obs2 = {ucode_addr2, halted2, step_fault2, alu_op2, alu_enable2, memory_op2,
                 dws2, bus2, reg_load2, reg_enable2};

  always #5 clk = ~clk;

  microcode_sequencer #(.OPCODE_WIDTH(OW), .STEP_WIDTH(SW), .NUM_REGS(NR), .FETCH_OPCODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .ucode_word(ucode_word),
    .mem_ready(mem_ready), .resume(resume), .ucode_addr(ucode_addr),
    .alu_op(alu_op), .alu_enable(alu_enable), .memory_op(memory_op),
    .data_word_selector(data_word_selector), .bus_selector(bus_selector),
    .reg_load(reg_load), .reg_enable(reg_enable), .halted(halted), .step_fault(step_fault)
  );

  microcode_sequencer #(.OPCODE_WIDTH(OW), .STEP_WIDTH(SW), .NUM_REGS(2), .FETCH_OPCODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .ucode_word(w2),
    .mem_ready(mem_ready), .resume(resume), .ucode_addr(ucode_addr2),
    .alu_op(alu_op2), .alu_enable(alu_enable2), .memory_op(memory_op2),
    .data_word_selector(dws2), .bus_selector(bus2),
    .reg_load(reg_load2), .reg_enable(reg_enable2), .halted(halted2), .step_fault(step_fault2)
  );

  function automatic logic [CW-1:0] mk(input logic [3:0] alu, input logic alue,
                                       input logic [2:0] mem, input logic dws,
                                       input logic bus, input logic [7:0] regs,
                                       input logic [3:0] seq);
    return {alu, alue, mem, dws, bus, regs, seq};
  endfunction

  // Expected observation at address a from the bench's own ROM table.
  function automatic obs_t model(input logic [AW-1:0] a, input logic h, input logic f);
    logic [CW-1:0] w;
    logic [2:0] m;
    logic [1:0] r;
    obs_t o;
    w = rom[a];
    o = '0;
    o.addr = a;
    o.halted = h;
    o.fault = f;
    if (!h) begin
      o.alu_op = w[21:18];
      o.alu_en = w[17];
      m = w[16:14];
      o.mem_op = (m == 3'd1 || m == 3'd2) ? m : 3'd0;
      o.dws = w[13];
      o.bus = w[12];
      for (int i = 0; i < int'(NR); i++) begin
        r = w[11 - 2 * i -: 2];
        o.rld[i] = (r == 2'd1);
        o.ren[i] = (r == 2'd2);
      end
    end
    return o;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    exp_q.push_back(model(8'd0, 1'b0, 1'b0));
    want = exp_q.pop_front();
    tests++;
    if (obs !== want) begin
      failed++;
      $display("FAIL reset_state: got %h want %h", obs, want);
    end
  endtask

  task automatic test_control_load();
    logic [AW-1:0] ea [2] = '{8'd40, 8'd41};
    rst_n = 1'b1;
    ir_opcode = 5'd5;
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(model(ea[c], 1'b0, 1'b0));
      @(negedge clk);
      want = exp_q.pop_front();
      tests++;
      if (obs !== want) begin
        failed++;
        $display("FAIL control_load c%0d: got %h want %h", c, obs, want);
      end
    end
  endtask

  task automatic test_stall();
    logic          mr [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] ea [6] = '{8'd41, 8'd41, 8'd41, 8'd42, 8'd43, 8'd44};
    for (int c = 0; c < 6; c++) begin
      mem_ready = mr[c];
      exp_q.push_back(model(ea[c], 1'b0, 1'b0));
      @(negedge clk);
      want = exp_q.pop_front();
      tests++;
      if (obs !== want) begin
        failed++;
        $display("FAIL stall c%0d: got %h want %h", c, obs, want);
      end
    end
  endtask

  task automatic test_priority();
    logic [OW-1:0] ir [4] = '{5'd6, 5'd6, 5'd7, 5'd7};
    logic [AW-1:0] ea [4] = '{8'd0, 8'd48, 8'd56, 8'd0};
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ir_opcode = ir[c];
      exp_q.push_back(model(ea[c], 1'b0, 1'b0));
      @(negedge clk);
      want = exp_q.pop_front();
      tests++;
      if (obs !== want) begin
        failed++;
        $display("FAIL priority c%0d: got %h want %h", c, obs, want);
      end
    end
  endtask

  task automatic test_halt();
    logic [OW-1:0] ir [5] = '{5'd3, 5'd3, 5'd5, 5'd5, 5'd2};
    logic          rs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [AW-1:0] ea [5] = '{8'd24, 8'd0, 8'd0, 8'd0, 8'd16};
    logic          eh [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 5; c++) begin
      ir_opcode = ir[c];
      resume = rs[c];
      exp_q.push_back(model(ea[c], eh[c], 1'b0));
      @(negedge clk);
      want = exp_q.pop_front();
      tests++;
      if (obs !== want) begin
        failed++;
        $display("FAIL halt_resume c%0d: got %h want %h", c, obs, want);
      end
    end
    resume = 1'b0;
  endtask

  task automatic test_step_wrap();
    logic [AW-1:0] a;
    logic f;
    ir_opcode = 5'd2;
    for (int c = 0; c < 9; c++) begin
      if (c < 7) begin
        a = AW'(17 + c);
        f = 1'b0;
      end else if (FAULT_EN) begin
        a = (c == 7) ? 8'd0 : 8'd16;
        f = 1'b1;
      end else begin
        a = (c == 7) ? 8'd16 : 8'd17;
        f = 1'b0;
      end
      exp_q.push_back(model(a, 1'b0, f));
      @(negedge clk);
      want = exp_q.pop_front();
      tests++;
      if (obs !== want) begin
        failed++;
        $display("FAIL step_wrap c%0d: got %h want %h", c, obs, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] ea [6] = '{8'd40, 8'd41, 8'd41, 8'd24, 8'd0, 8'd24};
    logic          eh [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      // Pull reset between edges before each phase (run, mid-stall, mid-halt).
      if (c == 0 || c == 3 || c == 5) begin
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(model(8'd0, 1'b0, 1'b0));
        want = exp_q.pop_front();
        tests++;
        if (obs !== want) begin
          failed++;
          $display("FAIL async_reset c%0d: got %h want %h", c, obs, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      ir_opcode = (c < 3) ? 5'd5 : 5'd3;
      mem_ready = (c == 5) ? 1'b1 : 1'b0;
      exp_q.push_back(model(ea[c], eh[c], 1'b0));
      @(negedge clk);
      want = exp_q.pop_front();
      tests++;
      if (obs !== want) begin
        failed++;
        $display("FAIL after_reset c%0d: got %h want %h", c, obs, want);
      end
    end
  endtask

  task automatic test_regs();
    logic [3:0] rf [3] = '{4'b01_10, 4'b10_01, 4'b11_11};
    logic [3:0] ex [3] = '{4'b01_10, 4'b10_01, 4'b00_00};
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      w2 = {4'd9, 1'b1, 3'd2, 1'b0, 1'b1, rf[c], SQ_NXT};
      exp2_q.push_back({8'd0, 1'b0, 1'b0, 4'd9, 1'b1, 3'd2, 1'b0, 1'b1, ex[c]});
      @(negedge clk);
      want2 = exp2_q.pop_front();
      tests++;
      if (obs2 !== want2) begin
        failed++;
        $display("FAIL regs2 c%0d: got %h want %h", c, obs2, want2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    resume = 1'b0;
    ir_opcode = 5'd5;
    w2 = {4'd9, 1'b1, 3'd2, 1'b0, 1'b1, 4'b01_10, SQ_NXT};
    for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    for (int i = 0; i < 8; i++) rom[16 + i] = mk(4'(i), 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 4'b0000);
    rom[0]  = mk(4'd3, 1'b1, 3'd0, 1'b0, 1'b0, 8'b01_10_11_00, SQ_CUL);
    rom[24] = mk(4'd5, 1'b1, 3'd0, 1'b1, 1'b1, 8'b01_01_01_01, SQ_HLT);
    rom[40] = mk(4'd1, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 4'b0000);
    rom[41] = mk(4'd2, 1'b1, 3'd1, 1'b0, 1'b1, 8'h00, 4'b0000);
    rom[42] = mk(4'd0, 1'b0, 3'd2, 1'b1, 1'b1, 8'b10_01_00_00, 4'b0000);
    rom[43] = mk(4'd4, 1'b1, 3'd5, 1'b0, 1'b0, 8'b00_00_00_11, 4'b0000);
    rom[44] = mk(4'd6, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, SQ_RST | SQ_HLT | SQ_NXT);
    rom[48] = mk(4'd8, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, SQ_CUL | SQ_NXT);
    rom[56] = mk(4'd7, 1'b1, 3'd0, 1'b0, 1'b0, 8'b00_01_00_00, SQ_NXT);

    test_reset();
    test_control_load();
    test_stall();
    test_priority();
    test_halt();
    test_step_wrap();
    test_async_reset();
    test_regs();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 5, width of latched opcode.
REQ-002 SHALL have parameter STEP_WIDTH, default 3, micro-step counter width; MAX_STEPS = 2**STEP_WIDTH.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of general registers driven, range 1..8.
REQ-004 SHALL have parameter FETCH_OPCODE, default 0, opcode of the fetch micro-routine.
REQ-005 SHALL derive CW_WIDTH = 14 + 2*NUM_REGS. Packing from MSB: alu_op[4], alu_enable, memory_op[3], data_word_selector, bus_selector, reg_op[2] per register (reg 0 first), reset, halt, control_unit_load, next_instr (LSB).
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 ir_opcode  in  OPCODE_WIDTH  opcode from instruction register.
REQ-009 ucode_word  in  CW_WIDTH  combinational microcode ROM data for ucode_addr.
REQ-010 mem_ready  in  1  memory handshake; 1 = current READ/WRITE completes this cycle.
REQ-011 resume  in  1  single-cycle pulse leaving HALTED.
REQ-012 ucode_addr  out  OPCODE_WIDTH+STEP_WIDTH  {opcode_q, step_q}.
REQ-013 alu_op / alu_enable / memory_op / data_word_selector / bus_selector  out  4/1/3/1/1  decoded fields.
REQ-014 reg_load, reg_enable  out  NUM_REGS each  one bit per register; LOAD=1 sets load, ENABLE=2 sets enable.
REQ-015 halted  out  1  high in HALTED state.
REQ-016 step_fault  out  1  sticky micro-step overflow flag.

Function
REQ-017 SHALL implement states RUN, STALL, HALTED.
REQ-018 Outputs SHALL be combinational decode of ucode_word in RUN and STALL, and all-zero in HALTED (ucode_addr still driven).
REQ-019 memory_op encodings 3..7 SHALL decode as NOP; reg_op encoding 3 SHALL decode as REG_NOP.
REQ-020 In RUN, if memory_op is READ/WRITE and mem_ready=0, SHALL enter STALL holding opcode_q/step_q; all other sequencing bits in the word SHALL be ignored that cycle.
REQ-021 In STALL, SHALL hold state and outputs until mem_ready=1, then act on the word as in RUN that cycle; mem_ready=1 in the first RUN cycle SHALL cause no stall.
REQ-022 Sequencing bits SHALL apply with priority reset > halt > control_unit_load > next_instr > increment.
REQ-023 reset bit: opcode_q<=FETCH_OPCODE, step_q<=0, step_fault<=0, state RUN.
REQ-024 halt bit: state<=HALTED, step_q<=0, opcode_q<=FETCH_OPCODE.
REQ-025 control_unit_load: opcode_q<=ir_opcode, step_q<=0.
REQ-026 next_instr: opcode_q<=FETCH_OPCODE, step_q<=0.
REQ-027 Otherwise step_q<=step_q+1; ucode_addr reflects new step one cycle after the controlling edge.
REQ-028 In HALTED, resume=1 SHALL return to RUN next cycle at {FETCH_OPCODE,0}; resume ignored in RUN/STALL.

Reset
REQ-029 rst_n low SHALL asynchronously set state RUN, opcode_q=FETCH_OPCODE, step_q=0, step_fault=0, halted=0.
REQ-030 Reset mid-STALL or mid-HALTED SHALL abandon the operation with no residual stall or halt after release.

Configuration
REQ-031 Macro MICROCODE_STEP_FAULT_EN defined: increment at step_q=MAX_STEPS-1 SHALL set step_fault=1 (sticky until reset or reset bit) and redirect to {FETCH_OPCODE,0}.
REQ-032 Macro undefined: step_q SHALL wrap to 0 within the same opcode; step_fault tied 0.

Verification
REQ-033 Reset release, ROM returns control_unit_load at {0,0}, ir_opcode=5 -> ucode_addr=5<<3 next cycle.
REQ-034 Word READ, mem_ready low 3 cycles -> outputs/address held 3 cycles, step advances cycle after mem_ready=1.
REQ-035 Word with halt+next_instr+reset set -> reset wins, RUN at {0,0}, halted stays 0.
REQ-036 halt word -> halted=1, all control outputs 0; resume pulse -> halted=0, ucode_addr=0 next cycle.
REQ-037 Opcode 2 with 8 plain increment words, macro defined -> step_fault=1, ucode_addr=0; undefined -> ucode_addr wraps to {2,0}, step_fault=0.
REQ-038 NUM_REGS=2, reg fields LOAD,ENABLE -> reg_load=2'b01, reg_enable=2'b10 (bit 0 = reg 0).
